// File: rtl/serializador.sv
// Parallel-to-serial transmitter: start bit, N data bits LSB first, stop bit.
// Every bit lasts DIV clocks; all state advances on the falling edge of clk.
module serializador #(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    input  logic         d_valid,
    output logic         d_ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_reg,   state_next;
    logic [N-1:0]  shift_reg,   shift_next;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    logic [DW-1:0] div_cnt_reg, div_cnt_next;
    logic          tx_reg,      tx_next;
    logic          ready_reg,   ready_next;
    logic          busy_reg,    busy_next;
    logic          done_reg,    done_next;
    logic          bit_end;

    assign bit_end = (div_cnt_reg == DIV_LAST);

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;
        tx_next      = tx_reg;
        done_next    = 1'b0;

        // Outside the bit boundary every non-idle state just advances the divider.
        if (state_reg != IDLE && !bit_end) begin
            div_cnt_next = div_cnt_reg + DW'(1);
        end

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (d_valid) begin
                    shift_next   = d;
                    bit_cnt_next = '0;
                    div_cnt_next = '0;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_cnt_next = '0;
                    tx_next      = shift_reg[0];
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_cnt_next = '0;
                    if (bit_cnt_reg == BIT_LAST) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_next[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    div_cnt_next = '0;
                    tx_next      = 1'b1;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == IDLE);
        busy_next  = !ready_next;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
            tx_reg      <= tx_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign tx      = tx_reg;
    assign d_ready = ready_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: three instances (N=8/DIV=4, N=8/DIV=1, N=1/DIV=2)
// checked cycle by cycle against a frame model built from bit-slot arithmetic.
module tb_serializador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] d = 8'h00;
    logic       dv_a = 1'b0, dv_b = 1'b0, dv_c = 1'b0;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;
    logic       rdy_c, tx_c, busy_c, done_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serializador #(.N(8), .DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .d(d), .d_valid(dv_a),
        .d_ready(rdy_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    serializador #(.N(8), .DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .d(d), .d_valid(dv_b),
        .d_ready(rdy_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    serializador #(.N(1), .DIV(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .d(d[0:0]), .d_valid(dv_c),
        .d_ready(rdy_c), .tx(tx_c), .busy(busy_c), .done(done_c)
    );

    int   sel = 0;
    logic o_tx, o_rdy, o_busy, o_done;

    always_comb begin
        o_tx = tx_a; o_rdy = rdy_a; o_busy = busy_a; o_done = done_a;
        if (sel == 1) begin
            o_tx = tx_b; o_rdy = rdy_b; o_busy = busy_b; o_done = done_b;
        end else if (sel == 2) begin
            o_tx = tx_c; o_rdy = rdy_c; o_busy = busy_c; o_done = done_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame slot 0 is the start bit, slots 1..n carry data LSB first, slot n+1 is stop.
    function automatic logic exp_tx(input logic [7:0] w, input int n, input int div, input int k);
        int slot;
        slot = k / div;
        if (slot == 0) return 1'b0;
        if (slot <= n) return w[slot-1];
        return 1'b1;
    endfunction

    task automatic set_dv(input logic v);
        dv_a = (sel == 0) ? v : 1'b0;
        dv_b = (sel == 1) ? v : 1'b0;
        dv_c = (sel == 2) ? v : 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"},    {31'd0, o_tx},   32'd1);
        check({tag, "_ready"}, {31'd0, o_rdy},  32'd1);
        check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        check({tag, "_done"},  {31'd0, o_done}, 32'd0);
    endtask

    // Called at a posedge with the DUT idle; accept happens at the next negedge.
    task automatic send(input logic [7:0] w, input int n, input int div,
                        input bit keep, input logic [7:0] nxt);
        int len;
        len = (n + 2) * div;
        d = w;
        set_dv(1'b1);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            check("frame_tx",    {31'd0, o_tx},   {31'd0, exp_tx(w, n, div, k)});
            check("frame_busy",  {31'd0, o_busy}, 32'd1);
            check("frame_ready", {31'd0, o_rdy},  32'd0);
            check("frame_done",  {31'd0, o_done}, 32'd0);
            d = 8'($urandom);
            set_dv(1'($urandom));
            if (k == len - 1) begin
                d = nxt;
                set_dv(keep);
            end
        end
        @(posedge clk);
        check("end_done",  {31'd0, o_done}, 32'd1);
        check("end_tx",    {31'd0, o_tx},   32'd1);
        check("end_busy",  {31'd0, o_busy}, 32'd0);
        check("end_ready", {31'd0, o_rdy},  32'd1);
        $display("frame sel=%0d word=%02h keep=%0d", sel, w, keep);
        if (!keep) begin
            @(posedge clk);
            check_idle("after");
        end
    endtask

    task automatic abort_frame(input logic [7:0] w, input int n, input int div, input int abort_k);
        d = w;
        set_dv(1'b1);
        for (int k = 0; k <= abort_k; k++) begin
            @(posedge clk);
            check("abort_tx", {31'd0, o_tx}, {31'd0, exp_tx(w, n, div, k)});
            set_dv(1'b0);
        end
        rst_n = 1'b0;
        #1;
        check_idle("abort_async");
        @(posedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            check_idle("abort_quiet");
        end
        $display("abort sel=%0d word=%02h at k=%0d", sel, w, abort_k);
    endtask

    initial begin
        logic [7:0] w0, w1;
        bit         kp;

        dv_a = 1'b1; dv_b = 1'b1; dv_c = 1'b1;
        d = 8'h5A;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            sel = 0; #0 check_idle("rst_a");
            sel = 1; #0 check_idle("rst_b");
            sel = 2; #0 check_idle("rst_c");
        end
        sel = 0;
        set_dv(1'b0);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            check_idle("idle_no_valid");
        end

        send(8'hA5, 8, 4, 1'b0, 8'h00);
        send(8'h00, 8, 4, 1'b1, 8'hFF);
        send(8'hFF, 8, 4, 1'b0, 8'h00);
        abort_frame(8'hC3, 8, 4, 17);
        send(8'h96, 8, 4, 1'b0, 8'h00);

        w0 = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            w1 = 8'($urandom);
            kp = 1'($urandom);
            send(w0, 8, 4, kp, w1);
            w0 = w1;
        end
        send(w0, 8, 4, 1'b0, 8'h00);

        sel = 1;
        @(posedge clk);
        send(8'h81, 8, 1, 1'b0, 8'h00);
        w0 = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            w1 = 8'($urandom);
            send(w0, 8, 1, 1'($urandom), w1);
            w0 = w1;
        end
        send(w0, 8, 1, 1'b0, 8'h00);
        abort_frame(8'h7E, 8, 1, 4);

        sel = 2;
        @(posedge clk);
        send(8'h01, 1, 2, 1'b1, 8'h00);
        send(8'h00, 1, 2, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom), 1, 2, 1'b0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
